seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed driver for the Basys 3 four-digit seven-segment display. It sits directly downstream of the sign-changer datapath and takes a 16-bit display word plus per-digit blank, minus and decimal-point masks. It scans the four anodes at a programmable rate and drives active-low segment, anode and decimal-point pins. Inputs are captured once per frame, so a value change mid-scan never shows mixed digits.

## Interface
- DIGIT_TICKS, default 100000: clkin cycles each digit is lit. Must be ≥ 2. Simulation benches use 4.
- clkin  in  1  system clock, 100 MHz on board.
- btnR  in  1  asynchronous, active-high reset.
- value  in  16  four hex nibbles. value[3:0] is digit 0 (rightmost, an[0]); value[15:12] is digit 3.
- blank  in  4  per-digit blank. 1 means the digit is dark and its anode is off.
- minus  in  4  per-digit minus. 1 means the digit shows only segment g.
- dp_mask  in  4  per-digit decimal point. 1 means dp is lit for that digit.
- seg  out  7  active-low segments. seg[0]=a … seg[6]=g.
- an  out  4  active-low anodes, one-hot-low while scanning.
- dp  out  1  active-low decimal point.
- frame  out  1  one-cycle pulse, high on the first cycle digit 0 is driven in each frame.

## Operation
- State machine with two states: OFF and SCAN.
- OFF is entered on reset.
  - Outputs: an=4'hF, seg=7'h7F, dp=1, frame=0.
  - Cleared: prescaler=0, idx=0, shadow registers (value=0, blank=4'hF, minus=0, dp=0).
- OFF → SCAN on the first clkin rising edge with btnR low. That edge loads the shadow registers from the inputs, drives digit 0 and pulses frame.
- In SCAN:
  - The prescaler counts 0…DIGIT_TICKS-1. At DIGIT_TICKS-1 it wraps to 0 and idx advances.
  - idx advances mod 4: 0→1→2→3→0.
  - Each idx wrap 3→0 reloads all shadow registers from the inputs and pulses frame.
  - Inputs are never sampled at any other time.
- Per-digit decode for digit idx, using shadow values, with priority blank > minus > hex:
  - blank: an[idx]=1 (all anodes off), seg=7'h7F, dp=1.
  - minus: an[idx]=0, seg=7'h3F.
  - hex nibble: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (all 7-bit hex).
  - dp=0 only when dp_mask[idx]=1 and the digit is not blanked.
- Non-selected anodes are always 1.
- seg, an, dp and frame are all registered. There are no combinational paths from inputs to outputs.

## Timing
- Each digit is held for exactly DIGIT_TICKS cycles. A frame is 4×DIGIT_TICKS cycles. The frame pulse period equals the frame length.
- Input-to-display latency: a change becomes visible at the next frame boundary. Worst case is 4×DIGIT_TICKS cycles.
- The first frame starts on the first edge after reset release. Digit 0 is visible in the cycle following that edge.
- Asserting btnR at any point forces the outputs to their reset values immediately, without waiting for a clock edge. This includes mid-digit and the cycle of a frame wrap.
- Inputs that change on the same edge as a frame reload: the value present at that edge is the one captured.

## Test plan
All scenarios use DIGIT_TICKS=4 and a 10 ns clkin.
- **Reset:** hold btnR=1 with the clock running, then pulse btnR mid-digit during a scan. Required: an=4'hF, seg=7'h7F, dp=1, frame=0, asynchronously, within the same cycle.
- **Positive value:** value=16'h0017, blank=4'b1100, minus=0, dp_mask=0. Required repeating sequence: an=1110/seg=78 for 4 cycles, an=1101/seg=79 for 4 cycles, an=1111 for 8 cycles. frame pulses every 16 cycles, coincident with an=1110.
- **Negative value:** value=16'h0017, minus=4'b0100, blank=4'b1000. Required: digit 2 shows an=1011/seg=3F; digits 0 and 1 are unchanged from the previous scenario.
- **No tearing:** switch value 16'h0017 → 16'h00A0 while an=1101. Required: the rest of the frame keeps the old digits. From the next frame, digit 0 shows seg=40 and digit 1 shows seg=08.
- **Decimal point:** dp_mask=4'b0011 with blank=4'b0001. Required: dp stays 1 during digit 0; dp=0 only while an=1101.
- **Hex sweep:** value steps 16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, one per frame, no blanking. Required: every digit matches the 16-entry decode list.

Source files
------------

// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan_ctrl: captured display inputs and the
// active-low pin outputs. The slave modport is the controller's view.
interface seg_scan_if;
   logic [15:0] value;
   logic [3:0]  blank;
   logic [3:0]  minus;
   logic [3:0]  dp_mask;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic        frame;

   modport master (
      output value, blank, minus, dp_mask,
      input  seg, an, dp, frame
   );

   modport slave (
      input  value, blank, minus, dp_mask,
      output seg, an, dp, frame
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed four-digit seven-segment scanner. Inputs are captured
// once per frame into shadow registers so a frame never shows mixed values.
module seg_scan_ctrl #(
   parameter int DIGIT_TICKS = 100000
) (
   input logic       clkin,
   input logic       btnR,
   seg_scan_if.slave bus
);

   localparam int             PW       = $clog2(DIGIT_TICKS);
   localparam logic [PW-1:0]  PRE_LAST = PW'(DIGIT_TICKS - 1);
   localparam logic [PW-1:0]  PRE_ONE  = PW'(1);

   typedef enum logic {ST_OFF = 1'b0, ST_SCAN = 1'b1} state_t;

   state_t        r_state;
   logic [PW-1:0] r_pre;
   logic [1:0]    r_idx;
   logic [15:0]   r_val;
   logic [3:0]    r_blank;
   logic [3:0]    r_minus;
   logic [3:0]    r_dpm;
   logic [6:0]    r_seg;
   logic [3:0]    r_an;
   logic          r_dp;
   logic          r_frame;

   state_t        w_state_nxt;
   logic [PW-1:0] w_pre_nxt;
   logic [1:0]    w_idx_nxt;
   logic          w_load;
   logic [15:0]   w_val_nxt;
   logic [3:0]    w_blank_nxt;
   logic [3:0]    w_minus_nxt;
   logic [3:0]    w_dpm_nxt;
   logic [3:0]    w_nib;
   logic [6:0]    w_seg_nxt;
   logic [3:0]    w_an_nxt;
   logic          w_dp_nxt;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      case (nib)
         4'h0:    hex_to_seg = 7'h40;
         4'h1:    hex_to_seg = 7'h79;
         4'h2:    hex_to_seg = 7'h24;
         4'h3:    hex_to_seg = 7'h30;
         4'h4:    hex_to_seg = 7'h19;
         4'h5:    hex_to_seg = 7'h12;
         4'h6:    hex_to_seg = 7'h02;
         4'h7:    hex_to_seg = 7'h78;
         4'h8:    hex_to_seg = 7'h00;
         4'h9:    hex_to_seg = 7'h10;
         4'hA:    hex_to_seg = 7'h08;
         4'hB:    hex_to_seg = 7'h03;
         4'hC:    hex_to_seg = 7'h46;
         4'hD:    hex_to_seg = 7'h21;
         4'hE:    hex_to_seg = 7'h06;
         4'hF:    hex_to_seg = 7'h0E;
         default: hex_to_seg = 7'h7F;
      endcase
   endfunction

   // Next-state, shadow reload and decode of the digit shown after this edge.
   always_comb begin
      w_state_nxt = r_state;
      w_pre_nxt   = r_pre;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      case (r_state)
         ST_OFF: begin
            w_state_nxt = ST_SCAN;
            w_pre_nxt   = '0;
            w_idx_nxt   = 2'd0;
            w_load      = 1'b1;
         end
         ST_SCAN: begin
            if (r_pre == PRE_LAST) begin
               w_pre_nxt = '0;
               w_idx_nxt = r_idx + 2'd1;
               w_load    = (r_idx == 2'd3);
            end else begin
               w_pre_nxt = r_pre + PRE_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_OFF;
         end
      endcase

      if (w_load) begin
         w_val_nxt   = bus.value;
         w_blank_nxt = bus.blank;
         w_minus_nxt = bus.minus;
         w_dpm_nxt   = bus.dp_mask;
      end else begin
         w_val_nxt   = r_val;
         w_blank_nxt = r_blank;
         w_minus_nxt = r_minus;
         w_dpm_nxt   = r_dpm;
      end

      // Decode priority: blank over minus over hex nibble.
      w_nib = w_val_nxt[{w_idx_nxt, 2'b00} +: 4];
      if (w_blank_nxt[w_idx_nxt]) begin
         w_an_nxt  = 4'hF;
         w_seg_nxt = 7'h7F;
         w_dp_nxt  = 1'b1;
      end else begin
         w_an_nxt  = ~(4'b0001 << w_idx_nxt);
         w_seg_nxt = w_minus_nxt[w_idx_nxt] ? 7'h3F : hex_to_seg(w_nib);
         w_dp_nxt  = ~w_dpm_nxt[w_idx_nxt];
      end
   end

   // State, counters, shadow and output registers.
   always_ff @(posedge clkin or posedge btnR) begin
      if (btnR) begin
         r_state <= ST_OFF;
         r_pre   <= '0;
         r_idx   <= 2'd0;
         r_val   <= 16'h0000;
         r_blank <= 4'hF;
         r_minus <= 4'h0;
         r_dpm   <= 4'h0;
         r_seg   <= 7'h7F;
         r_an    <= 4'hF;
         r_dp    <= 1'b1;
         r_frame <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pre   <= w_pre_nxt;
         r_idx   <= w_idx_nxt;
         r_val   <= w_val_nxt;
         r_blank <= w_blank_nxt;
         r_minus <= w_minus_nxt;
         r_dpm   <= w_dpm_nxt;
         r_seg   <= w_seg_nxt;
         r_an    <= w_an_nxt;
         r_dp    <= w_dp_nxt;
         r_frame <= w_load;
      end
   end

   assign bus.seg   = r_seg;
   assign bus.an    = r_an;
   assign bus.dp    = r_dp;
   assign bus.frame = r_frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: fixed vector table, hand corner sequences and
// random input changes checked every cycle against a frame-level model.
module tb_seg_scan_ctrl;

   localparam int DT = 4;
   localparam int FR = 4 * DT;
   localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic clkin = 1'b0;
   logic btnR  = 1'b0;

   seg_scan_if bus ();

   seg_scan_ctrl #(.DIGIT_TICKS(DT)) dut (
      .clkin (clkin),
      .btnR  (btnR),
      .bus   (bus)
   );

   always #5 clkin = ~clkin;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: cycles since reset release, snapshot at frame starts.
   bit          running = 1'b0;
   int unsigned cyc = 0;
   logic [15:0] s_val;
   logic [3:0]  s_blank, s_minus, s_dpm;

   always @(posedge clkin or posedge btnR) begin
      if (btnR) begin
         running = 1'b0;
      end else begin
         if (!running) begin
            running = 1'b1;
            cyc = 0;
         end else begin
            cyc++;
         end
         if (cyc % FR == 0) begin
            s_val   = bus.value;
            s_blank = bus.blank;
            s_minus = bus.minus;
            s_dpm   = bus.dp_mask;
         end
      end
   end

   function automatic void model_exp(output logic [3:0] an, output logic [6:0] seg,
                                     output logic dp, output logic fr);
      int d;
      an = 4'hF; seg = 7'h7F; dp = 1'b1; fr = 1'b0;
      if (running) begin
         d  = (cyc % FR) / DT;
         fr = (cyc % FR == 0);
         if (!s_blank[d]) begin
            an[d] = 1'b0;
            seg   = s_minus[d] ? 7'h3F : HEX[s_val[d*4 +: 4]];
            dp    = ~s_dpm[d];
         end
      end
   endfunction

   bit chk_en = 1'b0;

   always @(negedge clkin) begin
      logic [3:0] e_an; logic [6:0] e_seg; logic e_dp, e_fr;
      if (chk_en) begin
         model_exp(e_an, e_seg, e_dp, e_fr);
         n_vec++;
         if (bus.an !== e_an || bus.seg !== e_seg || bus.dp !== e_dp || bus.frame !== e_fr) begin
            n_err++;
            $display("FAIL model cyc=%0d: got an=%b seg=%h dp=%b frame=%b, expected an=%b seg=%h dp=%b frame=%b",
                     cyc, bus.an, bus.seg, bus.dp, bus.frame, e_an, e_seg, e_dp, e_fr);
         end
      end
   end

   task automatic cmp(input string name, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_rst(input string name);
      cmp({name, "_an"},    int'(bus.an),    int'(4'hF));
      cmp({name, "_seg"},   int'(bus.seg),   int'(7'h7F));
      cmp({name, "_dp"},    int'(bus.dp),    int'(1'b1));
      cmp({name, "_frame"}, int'(bus.frame), int'(1'b0));
   endtask

   task automatic set_in(input logic [15:0] v, input logic [3:0] b, input logic [3:0] m,
                         input logic [3:0] p);
      bus.value = v; bus.blank = b; bus.minus = m; bus.dp_mask = p;
   endtask

   // Advance negedge by negedge until the model is at the given frame phase.
   task automatic sync_to(input int phase);
      bit found = 1'b0;
      for (int k = 0; k < 2 * FR + 2; k++) begin
         @(negedge clkin);
         if (running && (cyc % FR == phase)) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         n_vec++;
         n_err++;
         $display("FAIL sync_to: phase %0d not reached within budget", phase);
      end
   endtask

   typedef struct {
      logic [15:0] v;
      logic [3:0]  b, m, p;
      logic [27:0] seg;
      logic [15:0] an;
      logic [3:0]  dp;
   } vec_t;

   vec_t tbl [9];

   initial begin
      tbl[0] = '{16'h0017, 4'b1100, 4'b0000, 4'b0000, {7'h7F, 7'h7F, 7'h79, 7'h78}, 16'hFFDE, 4'b1111};
      tbl[1] = '{16'h0017, 4'b1000, 4'b0100, 4'b0000, {7'h7F, 7'h3F, 7'h79, 7'h78}, 16'hFBDE, 4'b1111};
      tbl[2] = '{16'h00A0, 4'b1100, 4'b0000, 4'b0000, {7'h7F, 7'h7F, 7'h08, 7'h40}, 16'hFFDE, 4'b1111};
      tbl[3] = '{16'h0017, 4'b0001, 4'b0000, 4'b0011, {7'h40, 7'h40, 7'h79, 7'h7F}, 16'h7BDF, 4'b1101};
      tbl[4] = '{16'h3210, 4'b0000, 4'b0000, 4'b0000, {7'h30, 7'h24, 7'h79, 7'h40}, 16'h7BDE, 4'b1111};
      tbl[5] = '{16'h7654, 4'b0000, 4'b0000, 4'b0000, {7'h78, 7'h02, 7'h12, 7'h19}, 16'h7BDE, 4'b1111};
      tbl[6] = '{16'hBA98, 4'b0000, 4'b0000, 4'b0000, {7'h03, 7'h08, 7'h10, 7'h00}, 16'h7BDE, 4'b1111};
      tbl[7] = '{16'hFEDC, 4'b0000, 4'b0000, 4'b0000, {7'h0E, 7'h06, 7'h21, 7'h46}, 16'h7BDE, 4'b1111};
      tbl[8] = '{16'h1234, 4'b0000, 4'b1111, 4'b1111, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 16'h7BDE, 4'b0000};

      set_in(16'h0017, 4'b1100, 4'b0000, 4'b0000);

      // Reset held with the clock running.
      #1 btnR = 1'b1;
      repeat (3) @(negedge clkin);
      check_rst("rst_hold");
      btnR = 1'b0;
      chk_en = 1'b1;

      // Table vectors: each record applied, then one whole frame checked.
      foreach (tbl[i]) begin
         @(negedge clkin);
         set_in(tbl[i].v, tbl[i].b, tbl[i].m, tbl[i].p);
         sync_to(0);
         for (int c = 0; c < FR; c++) begin
            int d;
            if (c > 0) @(negedge clkin);
            d = c / DT;
            cmp($sformatf("tbl%0d_an_c%0d", i, c),  int'(bus.an),    int'(tbl[i].an[d*4 +: 4]));
            cmp($sformatf("tbl%0d_seg_c%0d", i, c), int'(bus.seg),   int'(tbl[i].seg[d*7 +: 7]));
            cmp($sformatf("tbl%0d_dp_c%0d", i, c),  int'(bus.dp),    int'(tbl[i].dp[d]));
            cmp($sformatf("tbl%0d_fr_c%0d", i, c),  int'(bus.frame), int'(c == 0));
         end
      end

      // No tearing: value changes while digit 1 is lit.
      @(negedge clkin);
      set_in(16'h0017, 4'b1100, 4'b0000, 4'b0000);
      sync_to(0);
      sync_to(4);
      set_in(16'h00A0, 4'b1100, 4'b0000, 4'b0000);
      for (int c = 4; c < 8; c++) begin
         if (c > 4) @(negedge clkin);
         cmp("tear_old_d1", int'(bus.seg), int'(7'h79));
      end
      sync_to(0);
      cmp("tear_new_d0", int'(bus.seg), int'(7'h40));
      sync_to(4);
      cmp("tear_new_d1", int'(bus.seg), int'(7'h08));

      // Asynchronous reset mid-digit and on the frame-wrap cycle.
      foreach (tbl[i]) if (i < 2) begin
         sync_to(i == 0 ? 5 : FR - 1);
         @(posedge clkin);
         #2 btnR = 1'b1;
         #1 check_rst(i == 0 ? "rst_mid" : "rst_wrap");
         @(negedge clkin);
         btnR = 1'b0;
      end

      // Random input changes, including just before frame boundaries.
      for (int k = 0; k < 30 * FR; k++) begin
         @(negedge clkin);
         if ($urandom_range(5, 0) == 0 || (running && cyc % FR == FR - 1))
            set_in(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      end

      @(negedge clkin);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
